// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder and the cache that talks to it:
// controller state encoding, operation encoding and default bus widths.
package memory_responder_pkg;

   localparam int MEM_ADDR_SIZE = 16;
   localparam int MEM_DATA_SIZE = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } mem_op_e;

endpackage

// File: rtl/memory_responder_mem_array.sv
// Word storage for the memory responder: synchronous write, index-addressed
// combinational read. Deliberately has no reset so contents survive rst.
module memory_responder_mem_array #(
   parameter int DATA_SIZE  = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] idx_i,
   input  logic [DATA_SIZE-1:0]  wdata_i,
   output logic [DATA_SIZE-1:0]  rdata_o
);

   logic [DATA_SIZE-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

   // Store the latched write data on the completion edge.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder. A request accepted in IDLE is completed
// LATENCY edges later; mem_ready pulses for one cycle afterwards.
// Optional feature: define MEM_RESPONDER_STAT_EN to add rd_count/wr_count
// completion counters (16-bit, wrapping).
//
//   state | meaning
//   IDLE  | waiting for mem_en_R / mem_en_W; latch request on accept
//   BUSY  | counting down; operation performed when counter reaches 0
//   DONE  | mem_ready high for this single cycle
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int ADDR_SIZE  = MEM_ADDR_SIZE,
   parameter int DATA_SIZE  = MEM_DATA_SIZE,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE-1:0] mem_addr,
   input  logic                 mem_en_R,
   input  logic                 mem_en_W,
   input  logic [DATA_SIZE-1:0] mem_in,
   output logic [DATA_SIZE-1:0] mem_out,
   output logic                 mem_ready
`ifdef MEM_RESPONDER_STAT_EN
   ,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
`endif
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   mem_state_e            state_q;
   mem_op_e               op_q;
   logic [3:0]            cnt_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DATA_SIZE-1:0]  wdata_q;
   logic [DATA_SIZE-1:0]  mem_out_q;
   logic                  mem_ready_q;
   logic [DATA_SIZE-1:0]  rd_data;
   logic                  mem_we;
   logic                  complete;
`ifdef MEM_RESPONDER_STAT_EN
   logic [15:0]           rd_count_q;
   logic [15:0]           wr_count_q;
`endif

   // Upper address bits only select aliases of the same word.
   generate
      if (ADDR_SIZE > DEPTH_LOG2) begin : g_addr_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^mem_addr[ADDR_SIZE-1:DEPTH_LOG2];
      end
   endgenerate

   assign complete = (state_q == ST_BUSY) && (cnt_q == 4'd0);
   assign mem_we   = complete && (op_q == OP_WRITE);

   memory_responder_mem_array #(
      .DATA_SIZE  (DATA_SIZE),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) mem_array (
      .clk     (clk),
      .we_i    (mem_we),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (rd_data)
   );

   // Request sequencing: accept, count down the latency, complete, pulse ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= '0;
         mem_out_q   <= '0;
         mem_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_ready_q <= 1'b0;
               if (mem_en_R || mem_en_W) begin
                  idx_q   <= mem_addr[DEPTH_LOG2-1:0];
                  wdata_q <= mem_in;
                  op_q    <= mem_en_W ? OP_WRITE : OP_READ;
                  cnt_q   <= LAT_M1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_q == 4'd0) begin
                  if (op_q == OP_READ) begin
                     mem_out_q <= rd_data;
                  end
                  mem_ready_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               mem_ready_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               mem_ready_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MEM_RESPONDER_STAT_EN
   // Completion counters; wrap naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else if (complete) begin
         if (op_q == OP_WRITE) begin
            wr_count_q <= wr_count_q + 16'd1;
         end else begin
            rd_count_q <= rd_count_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

   assign mem_out   = mem_out_q;
   assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance at LATENCY=4 and one at
// LATENCY=1 exercising back-to-back traffic.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic [15:0] addr0, addr1;
   logic        rd0, wr0, rd1, wr1;
   logic [31:0] din0, din1, dout0, dout1;
   logic        rdy0, rdy1;
`ifdef MEM_RESPONDER_STAT_EN
   logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   memory_responder #(.LATENCY(4)) u_dut (
      .clk       (clk),
      .rst       (rst0),
      .mem_addr  (addr0),
      .mem_en_R  (rd0),
      .mem_en_W  (wr0),
      .mem_in    (din0),
      .mem_out   (dout0),
      .mem_ready (rdy0)
`ifdef MEM_RESPONDER_STAT_EN
      ,
      .rd_count  (rdc0),
      .wr_count  (wrc0)
`endif
   );

   memory_responder #(.LATENCY(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst1),
      .mem_addr  (addr1),
      .mem_en_R  (rd1),
      .mem_en_W  (wr1),
      .mem_in    (din1),
      .mem_out   (dout1),
      .mem_ready (rdy1)
`ifdef MEM_RESPONDER_STAT_EN
      ,
      .rd_count  (rdc1),
      .wr_count  (wrc1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble inputs after accept, measure ready latency and width.
   task automatic txn(input int which, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [31:0] d, input int lat, input string tag);
      int   seen_at;
      logic r;
      seen_at = -1;
      @(negedge clk);
      if (which == 0) begin rd0 = rd; wr0 = wr; addr0 = a; din0 = d; end
      else            begin rd1 = rd; wr1 = wr; addr1 = a; din1 = d; end
      @(posedge clk);
      #1;
      if (which == 0) begin rd0 = 1'b0; wr0 = 1'b0; addr0 = 16'hFFFF; din0 = 32'h5A5A5A5A; end
      else            begin rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'hFFFF; din1 = 32'h5A5A5A5A; end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         r = (which == 0) ? rdy0 : rdy1;
         if (r) begin
            seen_at = k;
            break;
         end
      end
      chk({tag, " ready latency"}, 32'(seen_at), 32'(lat));
      @(posedge clk);
      #1;
      r = (which == 0) ? rdy0 : rdy1;
      chk({tag, " ready width"}, {31'd0, r}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   seen;
      rst0 = 1'b1; rst1 = 1'b1;
      rd0 = 1'b0; wr0 = 1'b0; addr0 = 16'h0; din0 = 32'h0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset ready", {31'd0, rdy0}, 32'd0);
      chk("reset mem_out", dout0, 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      chk("post-reset mem_out", dout0, 32'd0);

      // LATENCY=4 instance
      txn(0, 1'b0, 1'b1, 16'h0005, 32'hDEADBEEF, 4, "wr 0005");
      chk("wr leaves mem_out", dout0, 32'd0);
      txn(0, 1'b1, 1'b0, 16'h0005, 32'h0, 4, "rd 0005");
      chk("rd 0005 data", dout0, 32'hDEADBEEF);
      txn(0, 1'b1, 1'b1, 16'h0010, 32'h12345678, 4, "rw 0010");
      chk("rw is write, mem_out held", dout0, 32'hDEADBEEF);
      txn(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4, "rd 0010");
      chk("rd 0010 data", dout0, 32'h12345678);
      txn(0, 1'b1, 1'b0, 16'h0405, 32'h0, 4, "rd 0405");
      chk("rd 0405 alias", dout0, 32'hDEADBEEF);

      // reset in the middle of a write
      txn(0, 1'b0, 1'b1, 16'h0020, 32'h11112222, 4, "wr 0020");
      @(negedge clk);
      wr0 = 1'b1; addr0 = 16'h0020; din0 = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      wr0 = 1'b0; addr0 = 16'h0; din0 = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst0 = 1'b1;
      #1;
      chk("mid-busy reset ready", {31'd0, rdy0}, 32'd0);
      chk("mid-busy reset mem_out", dout0, 32'd0);
      @(negedge clk);
      rst0 = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (rdy0) seen = 1;
      end
      chk("no ready after abort", 32'(seen), 32'd0);
      txn(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4, "rd 0020");
      chk("rd 0020 prior content", dout0, 32'h11112222);

      // LATENCY=1 instance, back-to-back
      txn(1, 1'b0, 1'b1, 16'h0001, 32'h000000A1, 1, "l1 wr 1");
      txn(1, 1'b0, 1'b1, 16'h0002, 32'h000000B2, 1, "l1 wr 2");
      txn(1, 1'b0, 1'b1, 16'h0003, 32'h000000C3, 1, "l1 wr 3");
      chk("l1 writes keep mem_out", dout1, 32'd0);
      txn(1, 1'b1, 1'b0, 16'h0002, 32'h0, 1, "l1 rd 2");
      chk("l1 rd 2 data", dout1, 32'h000000B2);
      txn(1, 1'b1, 1'b0, 16'h0003, 32'h0, 1, "l1 rd 3");
      chk("l1 rd 3 data", dout1, 32'h000000C3);
`ifdef MEM_RESPONDER_STAT_EN
      chk("l1 wr_count", {16'd0, wrc1}, 32'd3);
      chk("l1 rd_count", {16'd0, rdc1}, 32'd2);
      chk("l4 wr_count", {16'd0, wrc0}, 32'd0);
      chk("l4 rd_count", {16'd0, rdc0}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_SIZE, default 16, SHALL be the request address width.
REQ-002 Parameter DATA_SIZE, default 32, SHALL be the data word width.
REQ-003 Parameter DEPTH_LOG2, default 10, SHALL set storage depth to 2**DEPTH_LOG2 words.
REQ-004 Parameter LATENCY, default 4, range 1..15, SHALL be the number of edges from request acceptance to mem_ready.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 mem_addr  input  ADDR_SIZE  SHALL be the word address of the request.
REQ-008 mem_en_R  input  1  SHALL be the read request.
REQ-009 mem_en_W  input  1  SHALL be the write request.
REQ-010 mem_in  input  DATA_SIZE  SHALL be the write data.
REQ-011 mem_out  output  DATA_SIZE  SHALL be the registered read data.
REQ-012 mem_ready  output  1  SHALL be the one-cycle completion pulse.

Function
REQ-013 Storage SHALL be indexed by mem_addr[DEPTH_LOG2-1:0]; upper address bits are ignored, so aliased addresses map to the same word.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE SHALL accept a request when mem_en_R or mem_en_W is high: latch address, data and operation, load the counter with LATENCY-1, and go to BUSY.
REQ-016 If mem_en_R and mem_en_W are both high in IDLE, the request SHALL be treated as a write.
REQ-017 BUSY SHALL decrement the counter each edge; at the edge where the counter is 0, it SHALL perform the latched operation and go to DONE.
REQ-018 A write SHALL update storage with the latched data; a read SHALL load mem_out from storage at the latched index.
REQ-019 DONE SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-020 An accept at edge t0 SHALL make mem_ready high in the cycle following edge t0+LATENCY.
REQ-021 Enable and data inputs in BUSY and DONE SHALL be ignored; only latched values are used.
REQ-022 The requester SHALL deassert its enables in the cycle mem_ready is high; an enable still high in the next IDLE cycle is a new request.
REQ-023 mem_out SHALL hold its value until the next read completes; writes SHALL NOT change mem_out.
REQ-024 mem_ready SHALL be a registered output (the decoded DONE state).

Reset
REQ-025 rst SHALL immediately force state=IDLE, counter=0, mem_ready=0 and mem_out=0, including mid-BUSY; the pending operation is discarded.
REQ-026 Storage contents SHALL NOT be affected by reset.

Configuration
REQ-027 With MEM_RESPONDER_STAT_EN defined, outputs rd_count[15:0] and wr_count[15:0] SHALL exist, reset to 0, increment at each read or write completion, and wrap 0xFFFF->0.
REQ-028 Without MEM_RESPONDER_STAT_EN, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The FSM state encoding and the default ADDR_SIZE/DATA_SIZE constants SHALL live in a shared package used by the cache and the responder.
REQ-030 Storage SHALL be one sub-module, mem_array: synchronous write, index-addressed read.

Verification
REQ-031 LATENCY=4: write addr 0x0005, data 0xDEADBEEF at edge t0 -> mem_ready high only after edge t0+4; mem_out unchanged.
REQ-032 Read addr 0x0005 after REQ-031 -> mem_out=0xDEADBEEF and mem_ready pulses for 1 cycle after edge t0+4.
REQ-033 Read addr 0x0405 (DEPTH_LOG2=10) -> mem_out=0xDEADBEEF (alias).
REQ-034 Read and write both high, addr 0x0010, data 0x12345678 -> write performed; a later read of 0x0010 returns 0x12345678.
REQ-035 rst pulsed 2 edges into a write of 0xCAFEF00D to 0x0020 -> no mem_ready; a read of 0x0020 returns its prior content; mem_out=0 just after reset.
REQ-036 LATENCY=1 with MEM_RESPONDER_STAT_EN: 3 writes then 2 reads back-to-back -> each mem_ready follows the accept edge by 1; wr_count=3, rd_count=2.
